// File: rtl/ooo_pkg.sv
// Shared out-of-order core types: default ROB depth, entry tag and ROB entry layout.
// Typedefs and constants only; no logic, so no latency or backpressure of its own.
package ooo_pkg;

  localparam int ROB_DEPTH = 8;
  localparam int ROB_TAG_W = $clog2(ROB_DEPTH);

  typedef logic [ROB_TAG_W-1:0] rob_tag_t;

  typedef struct packed {
    logic        valid;
    logic        done;
    logic [4:0]  rd;
    logic [31:0] data;
  } rob_entry_t;

endpackage

// File: rtl/rob_commit.sv
// In-order reorder-buffer commit stage; register write lands one cycle after the commit edge.
// Backpressure: alloc_ready = !full from registered count; ROB_COMMIT_BYPASS_EN lets a head completion commit at once.
module rob_commit
  import ooo_pkg::*;
#(
  parameter int DEPTH = ROB_DEPTH,
  localparam int TAG_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  output logic             alloc_ready,
  output logic [TAG_W-1:0] alloc_tag,
  input  logic             cmpl_valid,
  input  logic [TAG_W-1:0] cmpl_tag,
  input  logic [31:0]      cmpl_data,
  output logic             wr_enable,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic [TAG_W:0]   count,
  output logic             empty,
  output logic             full
);

  localparam logic [TAG_W:0]   CNT_FULL = (TAG_W+1)'(DEPTH);
  localparam logic [TAG_W:0]   CNT_ONE  = (TAG_W+1)'(1);
  localparam logic [TAG_W-1:0] TAG_ONE  = TAG_W'(1);

  rob_entry_t       entries [DEPTH];
  logic [TAG_W-1:0] head;
  logic [TAG_W-1:0] tail;

  rob_entry_t  head_ent;
  logic        alloc_fire;
  logic        cmpl_hit;
  logic        head_bypass;
  logic        commit_fire;
  logic [31:0] commit_data;

  assign full        = (count == CNT_FULL);
  assign empty       = (count == '0);
  assign alloc_ready = !full;
  assign alloc_tag   = tail;
  assign alloc_fire  = alloc_valid && alloc_ready;
  assign head_ent    = entries[head];

  // A completion aimed at the slot being allocated this cycle belongs to a stale tag.
  assign cmpl_hit = cmpl_valid && entries[cmpl_tag].valid && !entries[cmpl_tag].done
                    && !(alloc_fire && (cmpl_tag == tail));

`ifdef ROB_COMMIT_BYPASS_EN
  assign head_bypass = cmpl_hit && (cmpl_tag == head);
`else
  assign head_bypass = 1'b0;
`endif

  assign commit_fire = head_ent.valid && (head_ent.done || head_bypass);
  assign commit_data = head_ent.done ? head_ent.data : cmpl_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      wr_enable <= 1'b0;
      wr_addr   <= '0;
      wr_data   <= '0;
    end else if (flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i].valid <= 1'b0;
        entries[i].done  <= 1'b0;
      end
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      wr_enable <= 1'b0;
    end else begin
      if (cmpl_hit) begin
        entries[cmpl_tag].done <= 1'b1;
        entries[cmpl_tag].data <= cmpl_data;
      end
      if (alloc_fire) begin
        entries[tail].valid <= 1'b1;
        entries[tail].done  <= 1'b0;
        entries[tail].rd    <= alloc_rd;
        tail                <= tail + TAG_ONE;
      end
      // Placed after the completion update so a bypassed head is retired, not left done.
      if (commit_fire) begin
        entries[head].valid <= 1'b0;
        entries[head].done  <= 1'b0;
        head                <= head + TAG_ONE;
        wr_addr             <= head_ent.rd;
        wr_data             <= commit_data;
      end
      wr_enable <= commit_fire && (|head_ent.rd);
      unique case ({alloc_fire, commit_fire})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Directed bench for rob_commit at DEPTH=8: vector table plus full/wrap, flush, latency and reset sequences.
module tb_rob_commit;

`ifdef ROB_COMMIT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic        alloc_valid = 1'b0;
  logic [4:0]  alloc_rd = '0;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cmpl_valid = 1'b0;
  logic [2:0]  cmpl_tag = '0;
  logic [31:0] cmpl_data = '0;
  logic        wr_enable;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  count;
  logic        empty;
  logic        full;

  int tests = 0;
  int fails = 0;

  rob_commit #(.DEPTH(8)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
    .cmpl_valid(cmpl_valid), .cmpl_tag(cmpl_tag), .cmpl_data(cmpl_data),
    .wr_enable(wr_enable), .wr_addr(wr_addr), .wr_data(wr_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [4:0]  ard;
    logic        cv;
    logic [2:0]  ctag;
    logic [31:0] cdat;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [3:0]  cnt;
    logic [2:0]  tag;
  } vec_t;

  vec_t vecs [20];

  function automatic vec_t mk(bit av, int ard, bit cv, int ctag, int cdat,
                              bit we, int wa, int wd, int cnt, int tag);
    vec_t v;
    v.av = av;  v.ard = 5'(ard); v.cv = cv; v.ctag = 3'(ctag); v.cdat = 32'(cdat);
    v.we = we;  v.wa = 5'(wa);   v.wd = 32'(wd); v.cnt = 4'(cnt); v.tag = 3'(tag);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; alloc_valid = 1'b0; cmpl_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int waited;

    // Table: in-order retire of out-of-order completions, rd=0 retire, ignored completions.
    vecs[0]  = mk(0,0, 0,0,0,     0,0,0,0,0);
    vecs[1]  = mk(1,5, 0,0,0,     0,0,0,1,1);
    vecs[2]  = mk(1,6, 0,0,0,     0,0,0,2,2);
    vecs[3]  = mk(1,7, 0,0,0,     0,0,0,3,3);
    vecs[4]  = mk(0,0, 1,2,'hC,   0,0,0,3,3);
    vecs[5]  = mk(0,0, 1,1,'hB,   0,0,0,3,3);
    if (BYP) begin
      vecs[6] = mk(0,0, 1,0,'hA,  1,5,'hA,2,3);
      vecs[7] = mk(0,0, 0,0,0,    1,6,'hB,1,3);
      vecs[8] = mk(0,0, 0,0,0,    1,7,'hC,0,3);
      vecs[9] = mk(0,0, 0,0,0,    0,7,'hC,0,3);
    end else begin
      vecs[6] = mk(0,0, 1,0,'hA,  0,0,0,3,3);
      vecs[7] = mk(0,0, 0,0,0,    1,5,'hA,2,3);
      vecs[8] = mk(0,0, 0,0,0,    1,6,'hB,1,3);
      vecs[9] = mk(0,0, 0,0,0,    1,7,'hC,0,3);
    end
    vecs[10] = mk(0,0, 0,0,0,     0,7,'hC,0,3);
    vecs[11] = mk(1,0, 0,0,0,     0,7,'hC,1,4);
    vecs[12] = BYP ? mk(0,0, 1,3,'h55, 0,0,'h55,0,4) : mk(0,0, 1,3,'h55, 0,7,'hC,1,4);
    vecs[13] = mk(0,0, 0,0,0,     0,0,'h55,0,4);
    vecs[14] = mk(0,0, 0,0,0,     0,0,'h55,0,4);
    vecs[15] = mk(0,0, 1,6,'hDEAD,0,0,'h55,0,4);
    vecs[16] = mk(1,9, 0,0,0,     0,0,'h55,1,5);
    vecs[17] = BYP ? mk(0,0, 1,4,'h11, 1,9,'h11,0,5) : mk(0,0, 1,4,'h11, 0,0,'h55,1,5);
    vecs[18] = BYP ? mk(0,0, 1,4,'h22, 0,9,'h11,0,5) : mk(0,0, 1,4,'h22, 1,9,'h11,0,5);
    vecs[19] = mk(0,0, 0,0,0,     0,9,'h11,0,5);

    do_reset();
    chk("rst.alloc_ready", alloc_ready, 1);
    chk("rst.empty", empty, 1);
    chk("rst.full", full, 0);
    chk("rst.alloc_tag", alloc_tag, 0);
    chk("rst.wr_addr", wr_addr, 0);
    chk("rst.wr_data", wr_data, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("idle%0d.alloc_ready", i), alloc_ready, 1);
      chk($sformatf("idle%0d.empty", i), empty, 1);
      chk($sformatf("idle%0d.count", i), count, 0);
      chk($sformatf("idle%0d.wr_enable", i), wr_enable, 0);
    end

    for (int i = 0; i < 20; i++) begin
      alloc_valid = vecs[i].av; alloc_rd = vecs[i].ard;
      cmpl_valid = vecs[i].cv; cmpl_tag = vecs[i].ctag; cmpl_data = vecs[i].cdat;
      tick();
      alloc_valid = 1'b0; cmpl_valid = 1'b0;
      chk($sformatf("v%0d.wr_enable", i), wr_enable, vecs[i].we);
      chk($sformatf("v%0d.wr_addr", i), wr_addr, vecs[i].wa);
      chk($sformatf("v%0d.wr_data", i), wr_data, vecs[i].wd);
      chk($sformatf("v%0d.count", i), count, vecs[i].cnt);
      chk($sformatf("v%0d.alloc_tag", i), alloc_tag, vecs[i].tag);
      chk($sformatf("v%0d.empty", i), empty, vecs[i].cnt == 0);
    end

    // Fill to full, ninth allocation ignored, commit frees a slot only after the edge, tag wraps.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
      tick();
    end
    alloc_rd = 5'd20;
    tick();
    chk("full.full", full, 1);
    chk("full.alloc_ready", alloc_ready, 0);
    chk("full.count", count, 8);
    chk("full.alloc_tag", alloc_tag, 0);
    cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h99;
    tick();
    cmpl_valid = 1'b0;
    waited = 0;
    while (!wr_enable && waited < 4) begin
      tick();
      waited++;
    end
    chk("full.commit_seen", wr_enable, 1);
    chk("full.commit_count", count, 7);
    chk("full.commit_ready", alloc_ready, 1);
    chk("full.wrap_tag", alloc_tag, 0);
    chk("full.wr_addr", wr_addr, 1);
    chk("full.wr_data", wr_data, 32'h99);
    tick();
    alloc_valid = 1'b0;
    chk("full.refill_count", count, 8);
    chk("full.refill_full", full, 1);
    chk("full.refill_tag", alloc_tag, 1);

    // Flush with two non-head entries done and a same-cycle allocation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      alloc_valid = 1'b1; alloc_rd = 5'(i + 1);
      tick();
    end
    alloc_valid = 1'b0;
    cmpl_valid = 1'b1; cmpl_tag = 3'd1; cmpl_data = 32'h11;
    tick();
    cmpl_tag = 3'd2; cmpl_data = 32'h22;
    tick();
    cmpl_valid = 1'b0;
    chk("flush.pre_count", count, 4);
    flush = 1'b1; alloc_valid = 1'b1; alloc_rd = 5'd30;
    tick();
    flush = 1'b0; alloc_valid = 1'b0;
    chk("flush.count", count, 0);
    chk("flush.wr_enable", wr_enable, 0);
    chk("flush.empty", empty, 1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("flush.idle%0d.wr_enable", i), wr_enable, 0);
    end
    chk("flush.next_tag", alloc_tag, 0);
    alloc_valid = 1'b1; alloc_rd = 5'd8;
    tick();
    alloc_valid = 1'b0;
    chk("flush.post_count", count, 1);

    // Head completion latency, with and without bypass.
    do_reset();
    alloc_valid = 1'b1; alloc_rd = 5'd12;
    tick();
    alloc_valid = 1'b0;
    tick();
    cmpl_valid = 1'b1; cmpl_tag = 3'd0; cmpl_data = 32'h77;
    tick();
    cmpl_valid = 1'b0;
    chk("lat.n1.wr_enable", wr_enable, BYP);
    tick();
    chk("lat.n2.wr_enable", wr_enable, !BYP);
    chk("lat.wr_addr", wr_addr, 12);
    chk("lat.wr_data", wr_data, 32'h77);

    // Reset mid-stream beats flush and completion; nothing retires afterwards.
    alloc_valid = 1'b1; alloc_rd = 5'd3;
    tick();
    alloc_valid = 1'b0;
    cmpl_valid = 1'b1; cmpl_tag = 3'd1; cmpl_data = 32'h5;
    rst = 1'b1; flush = 1'b1;
    tick();
    rst = 1'b0; flush = 1'b0; cmpl_valid = 1'b0;
    chk("mrst.count", count, 0);
    chk("mrst.wr_addr", wr_addr, 0);
    chk("mrst.wr_data", wr_data, 0);
    chk("mrst.alloc_tag", alloc_tag, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("mrst.idle%0d.wr_enable", i), wr_enable, 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
